// File: rtl/eq_adapt_pkg.sv
// Shared definitions for the equalizer adaptation controller.
// State encodings, slicer level helpers and saturation helpers.
// No logic of its own; everything here is evaluated at elaboration or inlined.
package eq_adapt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAIN = 2'd1,
      ST_ACQ   = 2'd2,
      ST_TRACK = 2'd3
   } state_t;

   // +1.0 at nbf fractional bits; also the outer PAM-4 decision threshold.
   function automatic int lvl_one(input int nbf);
      return 1 << nbf;
   endfunction

   // Inner PAM-4 level (0.5).
   function automatic int lvl_half(input int nbf);
      return 1 << (nbf - 1);
   endfunction

   // Outer PAM-4 level (1.5).
   function automatic int lvl_3half(input int nbf);
      return 3 << (nbf - 1);
   endfunction

   // Clamp a signed value into the nbt-bit two's complement range.
   function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int nbt);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (nbt - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (nbt - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

   // Clamp an unsigned value into the nbt-bit unsigned range.
   function automatic logic [63:0] sat_u(input logic [63:0] v, input int nbt);
      logic [63:0] hi;
      hi = (64'd1 << nbt) - 64'd1;
      return (v > hi) ? hi : v;
   endfunction

endpackage

// File: rtl/eq_adapt_ctrl_mse.sv
// Windowed MSE estimator: square of I/Q error, accumulate over 2^MSE_WIN_LOG2 symbols.
// Square registered 1 cycle after i_err_valid, accumulate the next; o_mse 2 cycles after the last error.
// No backpressure; i_clr discards the partial window and anything still in the square stage.
module eq_mse_est
   import eq_adapt_pkg::*;
#(
   parameter int NBT_ERR      = 9,
   parameter int MSE_WIN_LOG2 = 8,
   parameter int NBT_MSE      = 16
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_clr,
   input  logic               i_err_valid,
   input  logic [NBT_ERR-1:0] i_err_I,
   input  logic [NBT_ERR-1:0] i_err_Q,
   output logic [NBT_MSE-1:0] o_mse,
   output logic               o_mse_valid
);

   localparam int PW    = 2 * NBT_ERR;
   localparam int SQ_W  = PW + 1;
   // Wide enough for a full window of worst-case squares, so it never wraps.
   localparam int ACC_W = SQ_W + MSE_WIN_LOG2;

   logic signed [NBT_ERR-1:0]    e_I, e_Q;
   logic signed [PW-1:0]         p_I, p_Q;
   logic [SQ_W-1:0]              sq, sq_nxt;
   logic                         sq_vld;
   logic [ACC_W-1:0]             acc, acc_sum, acc_shr;
   logic [MSE_WIN_LOG2-1:0]      win_cnt;

   // Squares are non-negative, so their sum is safely treated as unsigned.
   always_comb begin
      e_I     = i_err_I;
      e_Q     = i_err_Q;
      p_I     = PW'(e_I) * PW'(e_I);
      p_Q     = PW'(e_Q) * PW'(e_Q);
      sq_nxt  = {1'b0, $unsigned(p_I)} + {1'b0, $unsigned(p_Q)};
      acc_sum = acc + ACC_W'(sq);
      acc_shr = acc_sum >> MSE_WIN_LOG2;
   end

   // Square stage, accumulator and window counter; the window result is published on its last symbol.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         sq          <= '0;
         sq_vld      <= 1'b0;
         acc         <= '0;
         win_cnt     <= '0;
         o_mse       <= '0;
         o_mse_valid <= 1'b0;
      end else begin
         o_mse_valid <= 1'b0;
         sq_vld      <= i_err_valid & ~i_clr;
         if (i_err_valid)
            sq <= sq_nxt;
         if (i_clr) begin
            acc     <= '0;
            win_cnt <= '0;
         end else if (sq_vld) begin
            win_cnt <= win_cnt + MSE_WIN_LOG2'(1);
            if (win_cnt == '1) begin
               acc         <= '0;
               o_mse       <= NBT_MSE'(sat_u(64'(acc_shr), NBT_MSE));
               o_mse_valid <= 1'b1;
            end else begin
               acc <= acc_sum;
            end
         end
      end
   end

endmodule

// File: rtl/eq_adapt_ctrl.sv
// Adaptation controller: PAM slicer, saturated error, windowed MSE and TRAIN/ACQ/TRACK FSM.
// o_sym/o_err 1 cycle after a strobe; o_mse 3 cycles after a window's last strobe; state 1 cycle later.
// No backpressure; strobes must be at least 4 cycles apart.
module eq_adapt_ctrl
   import eq_adapt_pkg::*;
#(
   parameter int                          NBT_IN       = 12,
   parameter int                          NBF_IN       = 9,
   parameter int                          NBT_ERR      = 9,
   parameter int                          NBF_ERR      = 7,
   parameter int                          LEVELS       = 2,
   parameter int                          MSE_WIN_LOG2 = 8,
   parameter int                          NBT_MSE      = 16,
   parameter logic [NBT_MSE-1:0]          LOCK_TH      = 16'd1638,
   parameter logic [NBT_MSE-1:0]          UNLOCK_TH    = 16'd3277,
   parameter int                          LOCK_CNT     = 4,
   parameter int                          TRAIN_LEN    = 512,
   parameter int                          NBT_STEP     = 12,
   parameter logic signed [NBT_STEP-1:0]  STEP_ACQ     = 12'sh008,
   parameter logic signed [NBT_STEP-1:0]  STEP_TRK     = 12'sh001
) (
   input  logic                clk,
   input  logic                i_reset,
   input  logic                i_en_rx,
   input  logic                i_en_rate1,
   input  logic [NBT_IN-1:0]   i_data_I,
   input  logic [NBT_IN-1:0]   i_data_Q,
   input  logic [NBT_IN-1:0]   i_ref_I,
   input  logic [NBT_IN-1:0]   i_ref_Q,
   output logic [NBT_IN-1:0]   o_sym_I,
   output logic [NBT_IN-1:0]   o_sym_Q,
   output logic [NBT_ERR-1:0]  o_err_I,
   output logic [NBT_ERR-1:0]  o_err_Q,
   output logic                o_err_valid,
   output logic [NBT_STEP-1:0] o_step,
   output logic                o_adapt_en,
   output logic [NBT_MSE-1:0]  o_mse,
   output logic                o_mse_valid,
   output logic                o_lock,
   output logic [1:0]          o_state
);

   localparam int SHIFT = NBF_IN - NBF_ERR;
   localparam logic signed [NBT_IN-1:0] V_ONE  = NBT_IN'(lvl_one(NBF_IN));
   localparam logic signed [NBT_IN-1:0] V_HALF = NBT_IN'(lvl_half(NBF_IN));
   localparam logic signed [NBT_IN-1:0] V_3H   = NBT_IN'(lvl_3half(NBF_IN));
   localparam int TRN_W  = (TRAIN_LEN > 0) ? $clog2(TRAIN_LEN + 1) : 1;
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam logic [TRN_W-1:0]  TRAIN_END = TRN_W'(TRAIN_LEN);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

   state_t              state, state_nxt;
   logic                strobe, state_chg, win_clr, rst_dp;
   logic [TRN_W-1:0]    train_cnt;
   logic [GOOD_W-1:0]   good_cnt;
   logic signed [NBT_IN-1:0]  sym_I, sym_Q;
   logic signed [NBT_ERR-1:0] err_I, err_Q;

   // Ties go to the more positive level, so every threshold uses >=.
   function automatic logic signed [NBT_IN-1:0] slice(input logic signed [NBT_IN-1:0] v);
      if (LEVELS == 4) begin
         if (v >= V_ONE)
            return V_3H;
         else if (v >= 0)
            return V_HALF;
         else if (v >= -V_ONE)
            return -V_HALF;
         else
            return -V_3H;
      end else begin
         return (v >= 0) ? V_ONE : -V_ONE;
      end
   endfunction

   // Difference carried one bit wider, truncated to the error fraction, then clamped.
   function automatic logic signed [NBT_ERR-1:0] form_err(input logic signed [NBT_IN-1:0] d,
                                                          input logic signed [NBT_IN-1:0] r);
      logic signed [NBT_IN:0] diff;
      diff = $signed({d[NBT_IN-1], d}) - $signed({r[NBT_IN-1], r});
      diff = diff >>> SHIFT;
      return NBT_ERR'(sat_s(64'(diff), NBT_ERR));
   endfunction

   assign strobe    = i_en_rate1 & i_en_rx;
   assign state_chg = (state_nxt != state);
   assign win_clr   = state_chg | ~i_en_rx;
   assign rst_dp    = i_reset | ~i_en_rx;

   // Slice and form the error against the training reference only while training.
   always_comb begin
      sym_I = slice(i_data_I);
      sym_Q = slice(i_data_Q);
      err_I = form_err(i_data_I, (state == ST_TRAIN) ? i_ref_I : sym_I);
      err_Q = form_err(i_data_Q, (state == ST_TRAIN) ? i_ref_Q : sym_Q);
   end

   // Decision/error registers hold between strobes; disabling the receiver zeroes them.
   always_ff @(posedge clk) begin
      if (rst_dp) begin
         o_sym_I     <= '0;
         o_sym_Q     <= '0;
         o_err_I     <= '0;
         o_err_Q     <= '0;
         o_err_valid <= 1'b0;
      end else begin
         o_err_valid <= strobe;
         if (strobe) begin
            o_sym_I <= sym_I;
            o_sym_Q <= sym_Q;
            o_err_I <= err_I;
            o_err_Q <= err_Q;
         end
      end
   end

   eq_mse_est #(
      .NBT_ERR      (NBT_ERR),
      .MSE_WIN_LOG2 (MSE_WIN_LOG2),
      .NBT_MSE      (NBT_MSE)
   ) u_mse (
      .clk         (clk),
      .i_reset     (rst_dp),
      .i_clr       (win_clr),
      .i_err_valid (o_err_valid),
      .i_err_I     (o_err_I),
      .i_err_Q     (o_err_Q),
      .o_mse       (o_mse),
      .o_mse_valid (o_mse_valid)
   );

   // Training length and consecutive-good-window counters; both restart on any state change.
   always_ff @(posedge clk) begin
      if (rst_dp || state_chg) begin
         train_cnt <= '0;
         good_cnt  <= '0;
      end else begin
         if (state == ST_TRAIN && strobe && train_cnt != TRAIN_END)
            train_cnt <= train_cnt + TRN_W'(1);
         if (state == ST_ACQ && o_mse_valid)
            good_cnt <= (o_mse < LOCK_TH) ? good_cnt + GOOD_W'(1) : '0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (i_reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state and state-decoded outputs; losing receiver enable always returns to IDLE.
   always_comb begin
      state_nxt  = state;
      o_step     = '0;
      o_adapt_en = 1'b0;
      o_lock     = 1'b0;
      case (state)
         ST_IDLE: begin
            state_nxt = (TRAIN_LEN == 0) ? ST_ACQ : ST_TRAIN;
         end
         ST_TRAIN: begin
            o_step     = STEP_ACQ;
            o_adapt_en = 1'b1;
            if (train_cnt == TRAIN_END)
               state_nxt = ST_ACQ;
         end
         ST_ACQ: begin
            o_step     = STEP_ACQ;
            o_adapt_en = 1'b1;
            if (o_mse_valid && (o_mse < LOCK_TH) && (good_cnt == GOOD_LAST))
               state_nxt = ST_TRACK;
         end
         ST_TRACK: begin
            o_step     = STEP_TRK;
            o_adapt_en = 1'b1;
            o_lock     = 1'b1;
            if (o_mse_valid && (o_mse > UNLOCK_TH))
               state_nxt = ST_ACQ;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (!i_en_rx)
         state_nxt = ST_IDLE;
   end

   assign o_state = state;

endmodule

// File: tb/tb_eq_adapt_ctrl.sv
// Directed bench for eq_adapt_ctrl: slicer/error table on PAM-2 and PAM-4 instances,
// then training, lock, unlock, receiver-disable and mid-training reset sequences.
// Three instances share stimulus; the sequence instance uses TRAIN_LEN=16 and 16-symbol windows.
module tb_eq_adapt_ctrl;

   logic clk = 1'b0;
   logic i_reset = 1'b1, en_rx = 1'b0, en_r1 = 1'b0;
   logic signed [11:0] d_I = '0, d_Q = '0, r_I = '0, r_Q = '0;

   logic signed [11:0] a_sym_I, a_sym_Q, b_sym_I, b_sym_Q, c_sym_I, c_sym_Q;
   logic signed [8:0]  a_err_I, a_err_Q, b_err_I, b_err_Q, c_err_I, c_err_Q;
   logic signed [11:0] a_step, b_step, c_step;
   logic [15:0]        a_mse, b_mse, c_mse;
   logic [1:0]         a_state, b_state, c_state;
   logic a_ev, b_ev, c_ev, a_ad, b_ad, c_ad, a_mv, b_mv, c_mv, a_lock, b_lock, c_lock;

   always #5 clk = ~clk;

   eq_adapt_ctrl #(.LEVELS(2), .TRAIN_LEN(16), .MSE_WIN_LOG2(4)) u_a (
      .clk(clk), .i_reset(i_reset), .i_en_rx(en_rx), .i_en_rate1(en_r1),
      .i_data_I(d_I), .i_data_Q(d_Q), .i_ref_I(r_I), .i_ref_Q(r_Q),
      .o_sym_I(a_sym_I), .o_sym_Q(a_sym_Q), .o_err_I(a_err_I), .o_err_Q(a_err_Q),
      .o_err_valid(a_ev), .o_step(a_step), .o_adapt_en(a_ad), .o_mse(a_mse),
      .o_mse_valid(a_mv), .o_lock(a_lock), .o_state(a_state));

   eq_adapt_ctrl #(.LEVELS(2), .TRAIN_LEN(0)) u_b (
      .clk(clk), .i_reset(i_reset), .i_en_rx(en_rx), .i_en_rate1(en_r1),
      .i_data_I(d_I), .i_data_Q(d_Q), .i_ref_I(r_I), .i_ref_Q(r_Q),
      .o_sym_I(b_sym_I), .o_sym_Q(b_sym_Q), .o_err_I(b_err_I), .o_err_Q(b_err_Q),
      .o_err_valid(b_ev), .o_step(b_step), .o_adapt_en(b_ad), .o_mse(b_mse),
      .o_mse_valid(b_mv), .o_lock(b_lock), .o_state(b_state));

   eq_adapt_ctrl #(.LEVELS(4), .TRAIN_LEN(0)) u_c (
      .clk(clk), .i_reset(i_reset), .i_en_rx(en_rx), .i_en_rate1(en_r1),
      .i_data_I(d_I), .i_data_Q(d_Q), .i_ref_I(r_I), .i_ref_Q(r_Q),
      .o_sym_I(c_sym_I), .o_sym_Q(c_sym_Q), .o_err_I(c_err_I), .o_err_Q(c_err_Q),
      .o_err_valid(c_ev), .o_step(c_step), .o_adapt_en(c_ad), .o_mse(c_mse),
      .o_mse_valid(c_mv), .o_lock(c_lock), .o_state(c_state));

   int n_vec = 0;
   int n_bad = 0;
   int n_mse_a = 0;
   int mse_base;
   logic [15:0] last_mse_a = '0;

   // Capture every window result from the sequence instance.
   always @(negedge clk) begin
      if (a_mv === 1'b1) begin
         n_mse_a    = n_mse_a + 1;
         last_mse_a = a_mse;
      end
   end

   typedef struct {
      int d;
      int s2; int e2;
      int s4; int e4;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the sampling edge.
   task automatic do_strobe(input int i, input int q, input int ri, input int rq);
      d_I   = 12'(i);
      d_Q   = 12'(q);
      r_I   = 12'(ri);
      r_Q   = 12'(rq);
      en_r1 = 1'b1;
      @(posedge clk);
      #1;
      en_r1 = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_symI"}, a_sym_I, 0);
      chk({tag, "_symQ"}, a_sym_Q, 0);
      chk({tag, "_errI"}, a_err_I, 0);
      chk({tag, "_errQ"}, a_err_Q, 0);
      chk({tag, "_errv"}, a_ev, 0);
      chk({tag, "_step"}, a_step, 0);
      chk({tag, "_adapt"}, a_ad, 0);
      chk({tag, "_mse"}, a_mse, 0);
      chk({tag, "_msev"}, a_mv, 0);
      chk({tag, "_lock"}, a_lock, 0);
      chk({tag, "_state"}, a_state, 0);
   endtask

   initial begin
      //            data  pam2 sym/err   pam4 sym/err
      tbl[0] = '{  600,   512,   22,   768,  -42};
      tbl[1] = '{-2000,  -512, -256,  -768, -256};
      tbl[2] = '{  300,   512,  -53,   256,   11};
      tbl[3] = '{  700,   512,   47,   768,  -17};
      tbl[4] = '{   -1,  -512,  127,  -256,   63};
      tbl[5] = '{  512,   512,    0,   768,  -64};
      tbl[6] = '{    0,   512, -128,   256,  -64};
      tbl[7] = '{ 2047,   512,  255,   768,  255};
      tbl[8] = '{ -513,  -512,   -1,  -768,   63};
      tbl[9] = '{ -512,  -512,    0,  -256,  -64};

      // Reset state.
      idle(2);
      chk_idle("rst");
      i_reset = 1'b0;
      en_rx   = 1'b1;
      idle(3);
      chk("en_a_state", a_state, 1);
      chk("en_b_state", b_state, 2);
      chk("en_c_state", c_state, 2);
      chk("en_c_step", c_step, 8);
      chk("en_c_adapt", c_ad, 1);
      chk("en_b_lock", b_lock, 0);

      // Slicer and error table: I from entry k, Q from entry k+1.
      for (int k = 0; k < 10; k++) begin
         int kq;
         kq = (k + 1) % 10;
         do_strobe(tbl[k].d, tbl[kq].d, 0, 0);
         chk("t2_symI", b_sym_I, tbl[k].s2);
         chk("t2_errI", b_err_I, tbl[k].e2);
         chk("t2_symQ", b_sym_Q, tbl[kq].s2);
         chk("t2_errQ", b_err_Q, tbl[kq].e2);
         chk("t4_symI", c_sym_I, tbl[k].s4);
         chk("t4_errI", c_err_I, tbl[k].e4);
         chk("t4_symQ", c_sym_Q, tbl[kq].s4);
         chk("t4_errQ", c_err_Q, tbl[kq].e4);
         chk("t_errv", b_ev, 1);
         idle(3);
         chk("t_errv_pulse", c_ev, 0);
         chk("t4_hold", c_sym_I, tbl[k].s4);
      end

      // Training, acquisition and lock on the TRAIN_LEN=16 instance.
      i_reset = 1'b1;
      idle(1);
      i_reset = 1'b0;
      idle(2);
      chk("trn_state0", a_state, 1);
      for (int s = 1; s <= 16; s++) begin
         do_strobe(534, 534, 512, 512);
         chk("trn_errI", a_err_I, 5);
         chk("trn_errQ", a_err_Q, 5);
         chk("trn_state", a_state, 1);
         idle(3);
      end
      chk("acq_state", a_state, 2);
      chk("acq_step", a_step, 8);
      mse_base = n_mse_a;
      for (int s = 17; s <= 80; s++) begin
         do_strobe(534, 534, 0, 0);
         idle(3);
         if (s % 16 == 0) begin
            chk("acq_mse", last_mse_a, 50);
            chk("acq_nwin", n_mse_a - mse_base, (s - 16) / 16);
         end
         if (s == 79)
            chk("prelock_state", a_state, 2);
      end
      chk("lock_state", a_state, 3);
      chk("lock_lock", a_lock, 1);
      chk("lock_step", a_step, 1);

      // One bad window in TRACK drops back to ACQ.
      for (int s = 81; s <= 96; s++) begin
         do_strobe(850, 850, 0, 0);
         chk("bad_errI", a_err_I, 84);
         idle(3);
         if (s == 95)
            chk("prebad_state", a_state, 3);
      end
      chk("unlock_mse", last_mse_a, 14112);
      chk("unlock_state", a_state, 2);
      chk("unlock_lock", a_lock, 0);
      chk("unlock_step", a_step, 8);

      // Receiver disabled right after a window's last strobe: its result must never appear.
      for (int s = 97; s <= 111; s++) begin
         do_strobe(534, 534, 0, 0);
         idle(3);
      end
      mse_base = n_mse_a;
      do_strobe(534, 534, 0, 0);
      chk("dis_errv_before", a_ev, 1);
      en_rx = 1'b0;
      idle(1);
      chk_idle("dis");
      do_strobe(600, 600, 0, 0);
      chk("dis_strobe_errv", a_ev, 0);
      chk("dis_strobe_errI", a_err_I, 0);
      idle(5);
      chk("dis_no_mse", n_mse_a - mse_base, 0);
      chk("dis_state", a_state, 0);

      // Reset in the middle of training restarts the training count.
      en_rx = 1'b1;
      idle(2);
      chk("rt_state0", a_state, 1);
      for (int s = 0; s < 5; s++) begin
         do_strobe(534, 534, 512, 512);
         idle(3);
      end
      do_strobe(534, 534, 512, 512);
      i_reset = 1'b1;
      mse_base = n_mse_a;
      idle(1);
      chk_idle("rtr");
      i_reset = 1'b0;
      idle(2);
      chk("rtr_state1", a_state, 1);
      for (int s = 1; s <= 15; s++) begin
         do_strobe(534, 534, 512, 512);
         idle(3);
      end
      chk("rtr_still_train", a_state, 1);
      do_strobe(534, 534, 512, 512);
      idle(3);
      chk("rtr_acq", a_state, 2);
      chk("rtr_no_mse", n_mse_a - mse_base, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
